// File: rtl/datapath_sequencer.sv
// Sequences one command at a time into datapath control strobes.
// Done 1-5 cycles after the accepting edge; start is only sampled in IDLE.
module datapath_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  cmd,
    input  logic [2:0]  rd,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [1:0]  shift_in,
    input  logic [7:0]  imm8,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] CMD_MOVI = 3'b000;
    localparam logic [2:0] CMD_MOVR = 3'b001;
    localparam logic [2:0] CMD_ADD  = 3'b010;
    localparam logic [2:0] CMD_CMP  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_MVN  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_WIMM, S_LDA, S_LDB, S_EXEC, S_WREG, S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] cmd_q, rd_q, rn_q, rm_q;
    logic [1:0] shift_q;
    logic [7:0] imm8_q;

    // Fields are captured only on the accepting edge so later input churn is harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cmd_q   <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= '0;
            imm8_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                cmd_q   <= cmd;
                rd_q    <= rd;
                rn_q    <= rn;
                rm_q    <= rm;
                shift_q <= shift_in;
                imm8_q  <= imm8;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (cmd)
                        CMD_MOVI:                   state_nxt = S_WIMM;
                        CMD_MOVR, CMD_MVN:          state_nxt = S_LDB;
                        CMD_ADD, CMD_AND, CMD_CMP:  state_nxt = S_LDA;
                        default:                    state_nxt = S_DONE;
                    endcase
                end
            end
            S_WIMM: state_nxt = S_DONE;
            S_LDA:  state_nxt = S_LDB;
            S_LDB:  state_nxt = S_EXEC;
            S_EXEC: state_nxt = (cmd_q == CMD_CMP) ? S_DONE : S_WREG;
            S_WREG: state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs depend only on state and latched fields, so IDLE/reset drives all zeros.
    always_comb begin
        readnum     = '0;
        writenum    = '0;
        vsel        = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        write       = 1'b0;
        shift       = '0;
        ALUop       = '0;
        datapath_in = '0;
        done        = 1'b0;
        err         = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_WIMM: begin
                vsel        = 1'b1;
                write       = 1'b1;
                writenum    = rd_q;
                datapath_in = {{8{imm8_q[7]}}, imm8_q};
            end
            S_LDA: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            S_LDB: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = shift_q;
                asel  = (cmd_q == CMD_MOVR) || (cmd_q == CMD_MVN);
                if (cmd_q == CMD_CMP) loads = 1'b1;
                else                  loadc = 1'b1;
                case (cmd_q)
                    CMD_CMP: ALUop = 2'b01;
                    CMD_AND: ALUop = 2'b10;
                    CMD_MVN: ALUop = 2'b11;
                    default: ALUop = 2'b00;
                endcase
            end
            S_WREG: begin
                write    = 1'b1;
                writenum = rd_q;
            end
            S_DONE: begin
                done = 1'b1;
                err  = (cmd_q[2:1] == 2'b11);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Sequencer driving a behavioural register-file/ALU datapath; results are
// compared against an instruction-level model and a fixed vector table.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  cmd, rd, rn, rm;
    logic [1:0]  shift_in;
    logic [7:0]  imm8;
    logic [2:0]  readnum, writenum;
    logic        vsel, loada, loadb, asel, bsel, loadc, loads, write;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    logic        busy, done, err;

    always #5 clk = ~clk;

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .rd(rd), .rn(rn),
        .rm(rm), .shift_in(shift_in), .imm8(imm8), .readnum(readnum),
        .writenum(writenum), .vsel(vsel), .loada(loada), .loadb(loadb),
        .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads), .write(write),
        .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in), .busy(busy),
        .done(done), .err(err)
    );

    // Behavioural datapath: shifter 01 shl1, 10 lsr1, 11 asr1.
    logic        init_dp;
    logic [15:0] regs [8];
    logic [15:0] ra, rb, rc, sh_b, ain, bin, alu;
    logic        z;

    always_comb begin
        sh_b = rb;
        case (shift)
            2'b01: sh_b = {rb[14:0], 1'b0};
            2'b10: sh_b = {1'b0, rb[15:1]};
            2'b11: sh_b = {rb[15], rb[15:1]};
            default: ;
        endcase
        ain = asel ? 16'd0 : ra;
        bin = bsel ? datapath_in : sh_b;
        alu = ain + bin;
        case (ALUop)
            2'b01: alu = ain - bin;
            2'b10: alu = ain & bin;
            2'b11: alu = ~bin;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (init_dp) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            ra <= '0; rb <= '0; rc <= '0; z <= 1'b0;
        end else begin
            if (write) regs[writenum] <= vsel ? datapath_in : rc;
            if (loada) ra <= regs[readnum];
            if (loadb) rb <= regs[readnum];
            if (loadc) rc <= alu;
            if (loads) z <= (alu == 16'd0);
        end
    end

    int n_write, n_loads, n_strobe, n_done, n_err_stray;
    always @(negedge clk) begin
        if (!reset) begin
            if (write) n_write++;
            if (loads) n_loads++;
            if (write || loada || loadb || loadc || loads) n_strobe++;
            if (done) n_done++;
            if (err && !done) n_err_stray++;
        end
    end

    // Instruction-level reference model.
    logic [15:0] exp_regs [8];
    logic        exp_z;

    function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'b01:   return 16'(v * 2);
            2'b10:   return v / 2;
            2'b11:   return (v / 2) + (v >= 16'h8000 ? 16'h8000 : 16'h0);
            default: return v;
        endcase
    endfunction

    function automatic int isa_lat(input logic [2:0] c);
        case (c)
            3'd0:             return 2;
            3'd1, 3'd3, 3'd5: return 4;
            3'd2, 3'd4:       return 5;
            default:          return 1;
        endcase
    endfunction

    task automatic isa_apply(input logic [2:0] c, d, n, m, input logic [1:0] s,
                             input logic [7:0] i);
        logic [15:0] b, diff;
        b = shf(exp_regs[m], s);
        case (c)
            3'd0: exp_regs[d] = 16'($signed(i));
            3'd1: exp_regs[d] = b;
            3'd2: exp_regs[d] = exp_regs[n] + b;
            3'd3: begin diff = exp_regs[n] - b; exp_z = (diff == 16'd0); end
            3'd4: exp_regs[d] = exp_regs[n] & b;
            3'd5: exp_regs[d] = ~b;
            default: ;
        endcase
    endtask

    int n_checks, n_pass;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] reg_mismatch();
        logic [7:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) mask[i] = (regs[i] !== exp_regs[i]);
        return mask;
    endfunction

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 20) begin @(negedge clk); g++; end
        check({tag, " idle"}, busy, 0);
    endtask

    task automatic scramble();
        cmd = 3'($urandom); rd = 3'($urandom); rn = 3'($urandom);
        rm = 3'($urandom); shift_in = 2'($urandom); imm8 = 8'($urandom);
    endtask

    task automatic run_cmd(input logic [2:0] c, d, n, m, input logic [1:0] s,
                           input logic [7:0] i, input bit noise, input string tag,
                           output int lat);
        int w0, l0, st0, d0, e0;
        wait_idle(tag);
        w0 = n_write; l0 = n_loads; st0 = n_strobe; d0 = n_done; e0 = n_err_stray;
        start = 1'b1; cmd = c; rd = d; rn = n; rm = m; shift_in = s; imm8 = i;
        @(posedge clk); #1;
        start = noise;
        scramble();
        lat = 1;
        @(negedge clk);
        while (!done && lat < 20) begin
            if (noise) begin start = 1'($urandom); scramble(); end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, isa_lat(c));
        check({tag, " err"}, err, (c[2:1] == 2'b11));
        isa_apply(c, d, n, m, s, i);
        @(negedge clk);
        check({tag, " done one cycle"}, {done, busy}, 2'b00);
        check({tag, " done count"}, n_done - d0, 1);
        check({tag, " stray err"}, n_err_stray - e0, 0);
        check({tag, " regs"}, reg_mismatch(), 0);
        if (c == 3'd3) begin
            check({tag, " Z"}, z, exp_z);
            check({tag, " cmp no write"}, n_write - w0, 0);
        end
        if (c == 3'd2) check({tag, " add no loads"}, n_loads - l0, 0);
        if (c[2:1] == 2'b11) check({tag, " illegal no strobes"}, n_strobe - st0, 0);
    endtask

    typedef struct {
        logic [2:0]  c, d, n, m;
        logic [1:0]  s;
        logic [7:0]  i;
        int          lat;
        logic [15:0] val;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int lat, g, d0;
        logic [15:0] r2_old;

        tbl[0] = '{3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 8'h07, 2, 16'h0007};
        tbl[1] = '{3'd0, 3'd1, 3'd0, 3'd0, 2'b00, 8'h02, 2, 16'h0002};
        tbl[2] = '{3'd2, 3'd2, 3'd1, 3'd0, 2'b01, 8'h00, 5, 16'h0010};
        tbl[3] = '{3'd0, 3'd3, 3'd0, 3'd0, 2'b00, 8'hFB, 2, 16'hFFFB};
        tbl[4] = '{3'd3, 3'd6, 3'd3, 3'd3, 2'b00, 8'h00, 4, 16'h0001};
        tbl[5] = '{3'd5, 3'd4, 3'd0, 3'd0, 2'b00, 8'h00, 4, 16'hFFF8};
        tbl[6] = '{3'd7, 3'd5, 3'd1, 3'd2, 2'b11, 8'h55, 1, 16'h0000};
        tbl[7] = '{3'd4, 3'd5, 3'd3, 3'd0, 2'b00, 8'h00, 5, 16'h0003};
        tbl[8] = '{3'd1, 3'd6, 3'd0, 3'd3, 2'b10, 8'h00, 4, 16'h7FFD};

        reset = 1'b1; init_dp = 1'b1; start = 1'b0;
        cmd = '0; rd = '0; rn = '0; rm = '0; shift_in = '0; imm8 = '0;
        for (int k = 0; k < 8; k++) exp_regs[k] = '0;
        exp_z = 1'b0;
        #12;
        check("reset outputs", {readnum, writenum, vsel, loada, loadb, asel, bsel,
              loadc, loads, write, shift, ALUop, datapath_in, busy, done, err}, 0);
        @(negedge clk);
        reset = 1'b0; init_dp = 1'b0;

        for (int k = 0; k < 9; k++) begin
            run_cmd(tbl[k].c, tbl[k].d, tbl[k].n, tbl[k].m, tbl[k].s, tbl[k].i,
                    k == 2, $sformatf("vec%0d", k), lat);
            check($sformatf("vec%0d table latency", k), lat, tbl[k].lat);
            if (tbl[k].c == 3'd3)           check($sformatf("vec%0d table Z", k), z, tbl[k].val[0]);
            else if (tbl[k].c[2:1] != 2'b11) check($sformatf("vec%0d table Rd", k), regs[tbl[k].d], tbl[k].val);
            else                             check($sformatf("vec%0d table regs", k), regs[4], 16'hFFF8);
        end

        // Start held high through DONE is taken on the first IDLE edge.
        wait_idle("b2b");
        start = 1'b1; cmd = 3'b110; rd = 3'd2;
        g = 0;
        @(negedge clk);
        while (!done && g < 20) begin @(negedge clk); g++; end
        check("b2b illegal err", {done, err}, 2'b11);
        cmd = 3'd0; rd = 3'd7; imm8 = 8'h80;
        @(negedge clk);
        check("b2b idle gap", busy, 0);
        @(negedge clk);
        check("b2b accepted", busy, 1);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        check("b2b movi latency", lat, 2);
        isa_apply(3'd0, 3'd7, 3'd0, 3'd0, 2'b00, 8'h80);
        @(negedge clk);
        check("b2b R7", regs[7], 16'hFF80);

        // Reset in WREG must kill the write before the next edge.
        wait_idle("rst");
        r2_old = exp_regs[2];
        d0 = n_done;
        start = 1'b1; cmd = 3'd2; rd = 3'd2; rn = 3'd0; rm = 3'd1; shift_in = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        g = 0;
        @(negedge clk);
        while (!write && g < 10) begin @(negedge clk); g++; end
        check("rst reached WREG", write, 1);
        #2 reset = 1'b1;
        #1;
        check("rst async drop", {write, busy, done, err}, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst Rd kept", regs[2], r2_old);
        check("rst no done", n_done - d0, 0);

        for (int k = 0; k < 40; k++) begin
            run_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                    2'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", k), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
